// File: rtl/pwd_stream_matcher.sv
// pwd_stream_matcher: compares a valid/ready byte stream against a stored password in a 64x8 RAM
// Optional lockout after MAX_FAIL consecutive failed attempts: define PWD_MATCHER_LOCKOUT_EN.
module pwd_stream_matcher #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int MAX_FAIL = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   pwd_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic              locked
);

    typedef enum logic [1:0] {IDLE, CHECK, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] LP_CAP = {1'b1, {ADDR_W{1'b0}}};

    state_t          r_state, w_state_nxt;
    logic [ADDR_W:0] r_idx, w_idx_nxt;
    logic [ADDR_W:0] r_len, w_len_nxt;
    logic            r_bad, w_bad_nxt;
    logic            r_match, w_match_nxt;
    logic            w_locked;
    logic            w_hs;
    logic            w_bad_hs;
    logic            w_len_ok;
    logic [ADDR_W:0] w_inc;

    assign ram_addr = r_idx[ADDR_W-1:0];
    assign match    = r_match;
    assign locked   = w_locked;
    assign w_hs     = in_valid & in_ready;
    assign w_inc    = r_idx + 1'b1;
    assign w_bad_hs = r_bad | (in_data != ram_rdata);
    assign w_len_ok = (pwd_len != '0) && (pwd_len <= LP_CAP);

    // Next-state, datapath next values and handshake/status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_bad_nxt   = r_bad;
        w_match_nxt = r_match;
        busy        = (r_state == CHECK) || (r_state == DRAIN);
        in_ready    = busy & ~w_locked;
        done        = (r_state == DONE);
        case (r_state)
            IDLE: begin
                if (start && !w_locked) begin
                    w_len_nxt   = pwd_len;
                    w_idx_nxt   = '0;
                    w_match_nxt = 1'b0;
                    w_bad_nxt   = ~w_len_ok;
                    w_state_nxt = w_len_ok ? CHECK : DRAIN;
                end
            end
            CHECK: begin
                if (w_hs) begin
                    w_bad_nxt = w_bad_hs;
                    w_idx_nxt = w_inc;
                    if (in_last) begin
                        w_state_nxt = DONE;
                        w_match_nxt = (w_inc == r_len) ? ~w_bad_hs : 1'b0;
                    end else if (w_inc == r_len) begin
                        w_bad_nxt   = 1'b1;
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_hs && in_last) begin
                    w_state_nxt = DONE;
                    w_match_nxt = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_bad   <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_bad   <= w_bad_nxt;
            r_match <= w_match_nxt;
        end
    end

`ifdef PWD_MATCHER_LOCKOUT_EN
    localparam int               LP_FW  = $clog2(MAX_FAIL + 1);
    localparam logic [LP_FW-1:0] LP_MAX = LP_FW'(MAX_FAIL);

    logic [LP_FW-1:0] r_fail;
    logic             r_locked;
    logic [LP_FW-1:0] w_fail_inc;

    assign w_fail_inc = r_fail + LP_FW'(1);
    assign w_locked   = r_locked;

    // Count consecutive failed verdicts; lock out once the limit is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail   <= '0;
            r_locked <= 1'b0;
        end else if (r_state == DONE) begin
            if (r_match) begin
                r_fail <= '0;
            end else begin
                r_fail <= w_fail_inc;
                if (w_fail_inc == LP_MAX) r_locked <= 1'b1;
            end
        end
    end
`else
    assign w_locked = (MAX_FAIL < 0);
`endif

endmodule

// File: tb/tb_pwd_stream_matcher.sv
// tb_pwd_stream_matcher: directed self-checking bench for pwd_stream_matcher
module tb_pwd_stream_matcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] pwd_len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [5:0] ram_addr;
    logic [7:0] ram_rdata;
    logic       busy;
    logic       done;
    logic       match;
    logic       locked;
    logic [7:0] mem [64];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];

    pwd_stream_matcher dut (
        .clk(clk), .rst(rst), .start(start), .pwd_len(pwd_len),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata), .busy(busy), .done(done),
        .match(match), .locked(locked)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [6:0] len);
        start   = 1'b1;
        pwd_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic l, input logic [5:0] exp_addr);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_rdy"}, in_ready, 1);
        chk({tag, "_addr"}, ram_addr, exp_addr);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic verdict(input string tag, input logic exp_match);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_match"}, match, exp_match);
        chk({tag, "_rdy_done"}, in_ready, 0);
        chk({tag, "_busy_done"}, busy, 0);
        tick();
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_match_held"}, match, exp_match);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = "a";
        mem[1] = "b";
        mem[2] = "c";
        start = 1'b0; pwd_len = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        do_reset();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_match", match, 0);
        chk("rst_locked", locked, 0);
        chk("rst_addr", ram_addr, 0);

`ifdef PWD_MATCHER_LOCKOUT_EN
        for (int n = 0; n < 3; n++) begin
            go(3);
            beat("lk_a", "a", 1'b0, 0);
            beat("lk_x", "x", 1'b0, 1);
            beat("lk_c", "c", 1'b1, 2);
            verdict("lk", 1'b0);
            chk("lk_locked", locked, (n == 2) ? 1 : 0);
        end
        go(3);
        chk("lk_start_ignored", busy, 0);
        in_valid = 1'b1;
        chk("lk_rdy", in_ready, 0);
        in_valid = 1'b0;
        do_reset();
        chk("lk_cleared", locked, 0);
`endif

        go(3);
        chk("ok_busy", busy, 1);
        beat("ok_a", "a", 1'b0, 0);
        beat("ok_b", "b", 1'b0, 1);
        beat("ok_c", "c", 1'b1, 2);
        verdict("ok", 1'b1);

        go(3);
        chk("bad_match_cleared", match, 0);
        beat("bad_a", "a", 1'b0, 0);
        beat("bad_x", "x", 1'b0, 1);
        beat("bad_c", "c", 1'b1, 2);
        verdict("bad", 1'b0);

        go(3);
        beat("short_a", "a", 1'b0, 0);
        beat("short_b", "b", 1'b1, 1);
        verdict("short", 1'b0);

        go(3);
        beat("long_a", "a", 1'b0, 0);
        beat("long_b", "b", 1'b0, 1);
        beat("long_c", "c", 1'b0, 2);
        chk("long_drain_busy", busy, 1);
        chk("long_drain_done", done, 0);
        beat("long_d", "d", 1'b0, 3);
        beat("long_e", "e", 1'b1, 3);
        verdict("long", 1'b0);

        go(0);
        chk("len0_busy", busy, 1);
        beat("len0_a", "a", 1'b0, 0);
        beat("len0_b", "b", 1'b1, 0);
        verdict("len0", 1'b0);

        go(65);
        chk("len65_busy", busy, 1);
        beat("len65_a", "a", 1'b1, 0);
        verdict("len65", 1'b0);

        start = 1'b1; pwd_len = 3; in_valid = 1'b1; in_data = "a";
        chk("start_vld_rdy", in_ready, 0);
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("gap_busy", busy, 1);
        beat("gap_a", "a", 1'b0, 0);
        tick();
        start = 1'b1; pwd_len = 5;
        tick();
        start = 1'b0;
        tick();
        chk("gap_addr", ram_addr, 1);
        chk("gap_done", done, 0);
        beat("gap_b", "b", 1'b0, 1);
        beat("gap_c", "c", 1'b1, 2);
        verdict("gap", 1'b1);

        go(3);
        beat("abort_a", "a", 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", ram_addr, 0);
        chk("abort_match", match, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
